// File: rtl/k2_pkg.sv
// k2_pkg: shared types for the K2 accumulator core.
//   OPC_W    - opcode field width
//   opcode_e - instruction opcodes (12-15 decode as NOP)
//   state_e  - core control states
package k2_pkg;

    localparam int unsigned OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        NOP  = 4'd0,
        LDA  = 4'd1,
        LDB  = 4'd2,
        ADDA = 4'd3,
        ADDB = 4'd4,
        SUBA = 4'd5,
        OUTA = 4'd6,
        OUTB = 4'd7,
        JMP  = 4'd8,
        JC   = 4'd9,
        JZ   = 4'd10,
        HLT  = 4'd11
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

endpackage

// File: rtl/k2_alu.sv
// k2_alu: combinational add/subtract unit for the K2 core.
//   a, b - operands
//   sub  - 0: y = a + b, c = carry out; 1: y = a - b, c = 1 when no borrow (a >= b)
//   y    - result modulo 2**N
//   c    - carry / not-borrow flag
module k2_alu #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] y,
    output logic         c
);

    logic [N:0] sum;

    // a - b computed as a + ~b + 1, so bit N is the not-borrow flag
    always_comb begin
        if (sub) begin
            sum = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
        end else begin
            sum = {1'b0, a} + {1'b0, b};
        end
        y = sum[N-1:0];
        c = sum[N];
    end

endmodule

// File: rtl/k2_core_p.sv
// k2_core_p: parametrised K2 accumulator core with writable program memory.
//   clk, reset         - clock and synchronous active-high reset
//   prog_we/addr/data  - program memory write port, honoured only in IDLE
//   run                - start (IDLE) or restart (HALT) at pc 0
//   RO, ro_valid       - output register and its one-cycle update strobe
//   halted, busy, pc   - state and program counter visibility
module k2_core_p
    import k2_pkg::*;
#(
    parameter  int unsigned N          = 8,
    parameter  int unsigned PROG_DEPTH = 16,
    localparam int unsigned PC_W       = $clog2(PROG_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [OPC_W+N-1:0] prog_data,
    input  logic              run,
    output logic [N-1:0]      RO,
    output logic              ro_valid,
    output logic              halted,
    output logic              busy,
    output logic [PC_W-1:0]   pc
);

    logic [OPC_W+N-1:0] mem [PROG_DEPTH];

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [N-1:0]    ra_q, ra_d, rb_q, rb_d, ro_q, ro_d;
    logic            c_q, c_d;
    logic            ro_valid_q, ro_valid_d;
    logic            mem_we;

    logic [OPC_W+N-1:0] instr;
    opcode_e            op;
    logic [N-1:0]       imm;
    logic [PC_W-1:0]    target;
    logic [N-1:0]       alu_y;
    logic               alu_c;

    // Asynchronous fetch: the instruction at pc executes on the next edge
    assign instr  = mem[pc_q];
    assign op     = opcode_e'(instr[OPC_W+N-1:N]);
    assign imm    = instr[N-1:0];
    assign target = imm[PC_W-1:0];

    k2_alu #(
        .N (N)
    ) u_alu (
        .a   (ra_q),
        .b   (rb_q),
        .sub (op == SUBA),
        .y   (alu_y),
        .c   (alu_c)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        ro_d       = ro_q;
        c_d        = c_q;
        ro_valid_d = 1'b0;
        mem_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                mem_we = prog_we;
                if (run) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            RUN: begin
                pc_d = pc_q + PC_W'(1);
                case (op)
                    LDA:  ra_d = imm;
                    LDB:  rb_d = imm;
                    ADDA, SUBA: begin
                        ra_d = alu_y;
                        c_d  = alu_c;
                    end
                    ADDB: begin
                        rb_d = alu_y;
                        c_d  = alu_c;
                    end
                    OUTA: begin
                        ro_d       = ra_q;
                        ro_valid_d = 1'b1;
                    end
                    OUTB: begin
                        ro_d       = rb_q;
                        ro_valid_d = 1'b1;
                    end
                    JMP:  pc_d = target;
                    JC: begin
                        if (c_q) begin
                            pc_d = target;
                            c_d  = 1'b0;
                        end
                    end
                    JZ: begin
                        if (ra_q == '0) pc_d = target;
                    end
                    HLT: begin
                        state_d = HALT;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
            end
            HALT: begin
                if (run) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            ro_q       <= '0;
            c_q        <= 1'b0;
            ro_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            ro_q       <= ro_d;
            c_q        <= c_d;
            ro_valid_q <= ro_valid_d;
        end
    end

    // Program memory survives reset; a reset cycle blocks writes
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    assign RO       = ro_q;
    assign ro_valid = ro_valid_q;
    assign busy     = (state_q == RUN);
    assign halted   = (state_q == HALT);
    assign pc       = pc_q;

endmodule

// File: tb/tb_k2_core_p.sv
// tb_k2_core_p: directed self-checking bench for k2_core_p (N=8, PROG_DEPTH=16).
module tb_k2_core_p;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [11:0] prog_data;
    logic        run;
    logic [7:0]  RO;
    logic        ro_valid;
    logic        halted;
    logic        busy;
    logic [3:0]  pc;

    int errors = 0;
    int checks = 0;

    k2_core_p #(
        .N          (8),
        .PROG_DEPTH (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .run       (run),
        .RO        (RO),
        .ro_valid  (ro_valid),
        .halted    (halted),
        .busy      (busy),
        .pc        (pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [11:0] ins(input logic [3:0] op, input logic [7:0] imm);
        return {op, imm};
    endfunction

    task automatic wr(input logic [3:0] a, input logic [11:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step(1);
        prog_we   = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        step(1);
        run = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    logic [7:0] seen [4];
    int         nseen;
    int         budget;

    initial begin
        reset     = 1'b1;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        run       = 1'b0;

        // Reset state
        step(2);
        chk("rst_ro", RO, 0);
        chk("rst_ro_valid", ro_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        reset = 1'b0;
        step(5);
        chk("idle_pc", pc, 0);
        chk("idle_busy", busy, 0);
        chk("idle_halted", halted, 0);

        // Basic program: 5 + 3 -> RO
        wr(4'd0, ins(4'd1, 8'd5));
        wr(4'd1, ins(4'd2, 8'd3));
        wr(4'd2, ins(4'd3, 8'd0));
        wr(4'd3, ins(4'd6, 8'd0));
        wr(4'd4, ins(4'd11, 8'd0));
        pulse_run();
        chk("p1_busy", busy, 1);
        chk("p1_pc0", pc, 0);
        step(3);
        chk("p1_no_valid_yet", ro_valid, 0);
        step(1);
        chk("p1_ro_valid", ro_valid, 1);
        chk("p1_ro", RO, 8);
        step(1);
        chk("p1_valid_drop", ro_valid, 0);
        chk("p1_halted", halted, 1);
        chk("p1_not_busy", busy, 0);
        chk("p1_pc_halt", pc, 4);
        step(3);
        chk("p1_pc_hold", pc, 4);
        chk("p1_ro_hold", RO, 8);

        // Carry and taken JC; the JC at 7 falls through only if C was cleared
        do_reset();
        wr(4'd0, ins(4'd1, 8'd200));
        wr(4'd1, ins(4'd2, 8'd100));
        wr(4'd2, ins(4'd3, 8'd0));
        wr(4'd3, ins(4'd9, 8'd6));
        wr(4'd4, ins(4'd7, 8'd0));
        wr(4'd5, ins(4'd11, 8'd0));
        wr(4'd6, ins(4'd6, 8'd0));
        wr(4'd7, ins(4'd9, 8'd4));
        wr(4'd8, ins(4'd11, 8'd0));
        pulse_run();
        step(3);
        chk("p2_pc_before_jc", pc, 3);
        step(1);
        chk("p2_jc_taken", pc, 6);
        step(1);
        chk("p2_ro_valid", ro_valid, 1);
        chk("p2_ro", RO, 44);
        step(1);
        chk("p2_c_cleared_pc", pc, 8);
        chk("p2_single_pulse", ro_valid, 0);
        step(1);
        chk("p2_halted", halted, 1);
        chk("p2_ro_final", RO, 44);

        // Counting loop with JZ: expect outputs 2,1,0
        do_reset();
        wr(4'd0, ins(4'd1, 8'd3));
        wr(4'd1, ins(4'd2, 8'd1));
        wr(4'd2, ins(4'd5, 8'd0));
        wr(4'd3, ins(4'd6, 8'd0));
        wr(4'd4, ins(4'd10, 8'd6));
        wr(4'd5, ins(4'd8, 8'd2));
        wr(4'd6, ins(4'd11, 8'd0));
        pulse_run();
        nseen  = 0;
        budget = 0;
        while (!halted && budget < 40) begin
            step(1);
            budget++;
            if (ro_valid === 1'b1) begin
                if (nseen < 4) seen[nseen] = RO;
                nseen++;
            end
        end
        chk("p3_halted_in_budget", halted, 1);
        chk("p3_cycles", budget, 14);
        chk("p3_pulses", nseen, 3);
        chk("p3_val0", seen[0], 2);
        chk("p3_val1", seen[1], 1);
        chk("p3_val2", seen[2], 0);
        chk("p3_pc", pc, 6);

        // PC wrap 15 -> 0, with a write attempted during RUN
        do_reset();
        wr(4'd0, ins(4'd10, 8'd14));
        wr(4'd1, ins(4'd11, 8'd0));
        wr(4'd14, ins(4'd1, 8'd7));
        wr(4'd15, ins(4'd6, 8'd0));
        pulse_run();
        prog_we   = 1'b1;
        prog_addr = 4'd15;
        prog_data = ins(4'd7, 8'd0);
        step(1);
        prog_we   = 1'b0;
        chk("p4_jz_taken", pc, 14);
        step(1);
        chk("p4_pc15", pc, 15);
        step(1);
        chk("p4_wrap", pc, 0);
        chk("p4_ro_valid", ro_valid, 1);
        chk("p4_ro", RO, 7);
        step(2);
        chk("p4_halted", halted, 1);
        chk("p4_pc_halt", pc, 1);

        // Run from HALT restarts at 0 with RA=7 retained, so JZ falls through
        pulse_run();
        chk("p4_restart_pc", pc, 0);
        chk("p4_restart_busy", busy, 1);
        step(1);
        chk("p4_ra_retained", pc, 1);
        step(1);
        chk("p4_rehalt", halted, 1);
        chk("p4_ro_kept", RO, 7);

        // Reset mid-RUN after the output, then rerun from intact memory
        do_reset();
        pulse_run();
        step(3);
        chk("p5_pre_ro", RO, 7);
        do_reset();
        chk("p5_rst_ro", RO, 0);
        chk("p5_rst_valid", ro_valid, 0);
        chk("p5_rst_pc", pc, 0);
        chk("p5_rst_busy", busy, 0);
        step(2);
        chk("p5_idle_pc", pc, 0);
        pulse_run();
        step(3);
        chk("p5_rerun_valid", ro_valid, 1);
        chk("p5_rerun_ro", RO, 7);
        chk("p5_rerun_wrap", pc, 0);
        step(2);
        chk("p5_rerun_halted", halted, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
